// File: rtl/rpn_input_stage_if.sv
// Entry hand-off bus between the input stage and the rpn core.
interface rpn_input_stage_if;
  logic [7:0] entry_data;
  logic [1:0] entry_op;
  logic       entry_valid;
  logic       entry_ready;

  modport master (output entry_data, output entry_op, output entry_valid, input entry_ready);
  modport slave  (input entry_data, input entry_op, input entry_valid, output entry_ready);
endinterface

// File: rtl/rpn_input_stage.sv
// Key/switch synchroniser, per-key debouncer with press pulses, and a one-entry
// valid/ready buffer that captures operand and op code on each enter press.
module rpn_input_stage #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic               CLOCK_50,
  input  logic               resetb,
  input  logic [3:0]         key_n,
  input  logic [9:0]         sw_in,
  output logic [3:0]         press,
  output logic [3:0]         key_level,
  output logic               overrun,
  rpn_input_stage_if.master  entry
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       key_p0, key_p1;
  logic [9:0]       sw_p0, sw_p1;
  logic [CNT_W-1:0] cnt     [4];
  logic [CNT_W-1:0] cnt_nxt [4];
  logic [3:0]       level_nxt;
  logic [3:0]       press_nxt;
  logic             capture_ok;

  // stage p0/p1: two-flop synchronisers (keys idle high, switches idle low)
  always_ff @(posedge CLOCK_50) begin
    if (!resetb) begin
      key_p0 <= '1;
      key_p1 <= '1;
      sw_p0  <= '0;
      sw_p1  <= '0;
    end else begin
      key_p0 <= key_n;
      key_p1 <= key_p0;
      sw_p0  <= sw_in;
      sw_p1  <= sw_p0;
    end
  end

  // debounce: a differing sample advances the count, a matching one restarts it
  always_comb begin
    level_nxt = key_level;
    press_nxt = '0;
    for (int i = 0; i < 4; i++) begin
      cnt_nxt[i] = '0;
      if (key_p1[i] != key_level[i]) begin
        if (cnt[i] == CNT_LAST) begin
          level_nxt[i] = key_p1[i];
          press_nxt[i] = key_level[i] & ~key_p1[i];
        end else begin
          cnt_nxt[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetb) begin
      key_level <= '1;
      press     <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      key_level <= level_nxt;
      press     <= press_nxt;
      for (int i = 0; i < 4; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  // capture lands on the same edge as the enter pulse, so a consume on that edge frees the slot
  assign capture_ok = !entry.entry_valid || entry.entry_ready;

  always_ff @(posedge CLOCK_50) begin
    if (!resetb) begin
      entry.entry_data  <= '0;
      entry.entry_op    <= '0;
      entry.entry_valid <= 1'b0;
      overrun           <= 1'b0;
    end else if (press_nxt[0]) begin
      if (capture_ok) begin
        entry.entry_data  <= sw_p1[7:0];
        entry.entry_op    <= sw_p1[9:8];
        entry.entry_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (entry.entry_valid && entry.entry_ready) begin
      entry.entry_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rpn_input_stage.sv
// Bench for rpn_input_stage with a four-sample debounce window.
module tb_rpn_input_stage;

  logic       clk;
  logic       resetb;
  logic [3:0] key_n;
  logic [9:0] sw_in;
  logic [3:0] press;
  logic [3:0] key_level;
  logic       overrun;

  rpn_input_stage_if ent ();

  rpn_input_stage #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .CLOCK_50  (clk),
    .resetb    (resetb),
    .key_n     (key_n),
    .sw_in     (sw_in),
    .press     (press),
    .key_level (key_level),
    .overrun   (overrun),
    .entry     (ent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [1:0] op;
  } exp_t;

  typedef struct {
    int         k;
    int         low;
    logic [9:0] sw;
    int         exp;
  } vec_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   press_cnt [4] = '{0, 0, 0, 0};

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic enter_press();
    key_n[0] = 1'b0;
    tick(8);
    key_n[0] = 1'b1;
    tick(10);
  endtask

  // consumer side: every accepted entry is matched against the scoreboard head
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) if (press[i]) press_cnt[i]++;
    if (resetb && ent.entry_valid && ent.entry_ready) begin
      if (sbq.size() == 0) begin
        check("sb_unexpected_entry", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("sb_data", int'(ent.entry_data), int'(e.d));
        check("sb_op", int'(ent.entry_op), int'(e.op));
      end
    end
  end

  initial begin
    vec_t vecs [8];
    int   base [4];

    vecs[0] = '{k: 0, low: 3, sw: 10'h111, exp: 0};
    vecs[1] = '{k: 0, low: 4, sw: 10'h2C3, exp: 1};
    vecs[2] = '{k: 0, low: 7, sw: 10'h0FF, exp: 1};
    vecs[3] = '{k: 1, low: 5, sw: 10'h000, exp: 1};
    vecs[4] = '{k: 2, low: 2, sw: 10'h000, exp: 0};
    vecs[5] = '{k: 3, low: 4, sw: 10'h000, exp: 1};
    vecs[6] = '{k: 0, low: 5, sw: 10'h300, exp: 1};
    vecs[7] = '{k: 3, low: 3, sw: 10'h000, exp: 0};

    resetb          = 1'b0;
    key_n           = 4'hF;
    sw_in           = 10'h000;
    ent.entry_ready = 1'b0;
    tick(1);
    check("rst_press", int'(press), 0);
    check("rst_key_level", int'(key_level), 'hF);
    check("rst_valid", int'(ent.entry_valid), 0);
    check("rst_data", int'(ent.entry_data), 0);
    check("rst_op", int'(ent.entry_op), 0);
    check("rst_overrun", int'(overrun), 0);
    resetb = 1'b1;

    // clean press with exact latency
    sw_in = 10'h0A9;
    tick(3);
    sbq.push_back('{d: 8'hA9, op: 2'b00});
    key_n[0] = 1'b0;
    tick(5);
    check("lat_press_early", int'(press[0]), 0);
    tick(1);
    check("lat_press", int'(press[0]), 1);
    check("lat_valid", int'(ent.entry_valid), 1);
    check("lat_data", int'(ent.entry_data), 'hA9);
    check("lat_op", int'(ent.entry_op), 0);
    tick(1);
    check("lat_press_single", int'(press[0]), 0);
    tick(3);
    base[0] = press_cnt[0];
    key_n[0] = 1'b1;
    tick(12);
    check("release_no_pulse", press_cnt[0] - base[0], 0);
    check("release_level", int'(key_level), 'hF);

    ent.entry_ready = 1'b1;
    tick(1);
    ent.entry_ready = 1'b0;
    check("consume_valid", int'(ent.entry_valid), 0);

    // glitch rejection
    base[0] = press_cnt[0];
    key_n[0] = 1'b0; tick(3);
    key_n[0] = 1'b1; tick(1);
    key_n[0] = 1'b0; tick(3);
    key_n[0] = 1'b1; tick(10);
    check("glitch_press", press_cnt[0] - base[0], 0);
    check("glitch_level", int'(key_level[0]), 1);
    check("glitch_valid", int'(ent.entry_valid), 0);

    // overrun
    sw_in = 10'h0A9;
    tick(3);
    sbq.push_back('{d: 8'hA9, op: 2'b00});
    enter_press();
    check("ovr_first_valid", int'(ent.entry_valid), 1);
    sw_in = 10'h355;
    tick(3);
    enter_press();
    check("ovr_data_kept", int'(ent.entry_data), 'hA9);
    check("ovr_op_kept", int'(ent.entry_op), 0);
    check("ovr_flag", int'(overrun), 1);
    ent.entry_ready = 1'b1;
    tick(1);
    ent.entry_ready = 1'b0;
    check("ovr_consumed", int'(ent.entry_valid), 0);
    check("ovr_sticky", int'(overrun), 1);

    // consume and capture on the same edge
    sw_in = 10'h0A9;
    tick(3);
    sbq.push_back('{d: 8'hA9, op: 2'b00});
    enter_press();
    sw_in = 10'h212;
    tick(3);
    sbq.push_back('{d: 8'h12, op: 2'b10});
    key_n[0] = 1'b0;
    tick(5);
    ent.entry_ready = 1'b1;
    tick(1);
    ent.entry_ready = 1'b0;
    check("simul_press", int'(press[0]), 1);
    check("simul_valid", int'(ent.entry_valid), 1);
    check("simul_data", int'(ent.entry_data), 'h12);
    check("simul_op", int'(ent.entry_op), 2);
    check("simul_overrun", int'(overrun), 1);
    tick(4);
    key_n[0] = 1'b1;
    tick(10);
    ent.entry_ready = 1'b1;
    tick(1);
    ent.entry_ready = 1'b0;

    // reset mid-debounce with an entry pending
    sw_in = 10'h0A9;
    tick(3);
    sbq.push_back('{d: 8'hA9, op: 2'b00});
    enter_press();
    key_n[2] = 1'b0;
    tick(4);
    resetb = 1'b0;
    tick(1);
    sbq.delete();
    resetb = 1'b1;
    check("mid_rst_valid", int'(ent.entry_valid), 0);
    check("mid_rst_overrun", int'(overrun), 0);
    check("mid_rst_level", int'(key_level), 'hF);
    tick(5);
    check("mid_rst_no_early", int'(press[2]), 0);
    tick(1);
    check("mid_rst_press", int'(press[2]), 1);
    check("mid_rst_level_low", int'(key_level[2]), 0);
    key_n[2] = 1'b1;
    tick(10);

    // table of key pulses with the core always ready
    ent.entry_ready = 1'b1;
    foreach (vecs[v]) begin
      sw_in = vecs[v].sw;
      tick(3);
      for (int i = 0; i < 4; i++) base[i] = press_cnt[i];
      if (vecs[v].exp == 1 && vecs[v].k == 0)
        sbq.push_back('{d: vecs[v].sw[7:0], op: vecs[v].sw[9:8]});
      key_n[vecs[v].k] = 1'b0;
      tick(vecs[v].low);
      key_n = 4'hF;
      tick(10);
      for (int i = 0; i < 4; i++)
        check($sformatf("vec%0d_press%0d", v, i), press_cnt[i] - base[i],
              (i == vecs[v].k) ? vecs[v].exp : 0);
      check($sformatf("vec%0d_overrun", v), int'(overrun), 0);
    end
    ent.entry_ready = 1'b0;
    tick(2);
    check("sb_drained", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rpn_input_stage.md
Name: rpn_input_stage

Overview:
- Front-end conditioning stage directly upstream of the rpn calculator core.
- Synchronises and debounces the active-low KEY pushbuttons and emits one-cycle press pulses.
- Synchronises SW and captures an 8-bit operand plus 2-bit op code on each debounced enter press (KEY[0]).
- Presents the captured entry to the core through a one-entry valid/ready buffer.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive synchronised cycles a key must differ from its stable state before the change is accepted (10 ms at 50 MHz; benches override to 4)
CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES

Ports:
CLOCK_50  input  1  system clock, all state on rising edge
resetb  input  1  synchronous active-low reset, sampled on rising edge of CLOCK_50
key_n  input  4  raw pushbuttons, active-low, asynchronous to CLOCK_50
sw_in  input  10  raw slide switches, asynchronous
press  output  4  one-cycle pulse per debounced key press (1->0 of stable state)
key_level  output  4  debounced stable key state, active-low
entry_data  output  8  captured operand, sw_in[7:0]
entry_op  output  2  captured op code, sw_in[9:8]
entry_valid  output  1  entry buffer holds an unconsumed entry
entry_ready  input  1  core accepts entry on any edge where entry_valid & entry_ready
overrun  output  1  sticky: an enter press was dropped because the buffer was full

Behaviour:
- Reset (resetb low at an edge):
  - sync flops and key_level = 4'b1111; counters = 0; press = 0.
  - entry_data = 0, entry_op = 0, entry_valid = 0, overrun = 0.
  - Reset overrides every event in the same cycle, including mid-debounce and a pending entry, which is discarded.
- Synchronisation: each key_n bit and each sw_in bit passes through a 2-flop synchroniser; sync flops reset to 1 for keys and 0 for switches.
- Debounce, independent per key i:
  - Counter cnt[i]. If the synchronised key equals key_level[i], cnt[i] <= 0.
  - Otherwise cnt[i] increments.
  - On the edge where the DEBOUNCE_CYCLES-th consecutive differing sample is seen, key_level[i] <= synchronised value and cnt[i] <= 0.
  - Any matching sample before then restarts the count, so glitches shorter than DEBOUNCE_CYCLES samples produce no change.
- press[i] is registered and asserted for exactly one cycle, at the same edge key_level[i] goes 1->0.
  - Releases (0->1) produce no pulse.
  - A key held low produces a single pulse.
- Latency: a key_n low first sampled at edge E0 and held yields press high after edge E0+DEBOUNCE_CYCLES+1. With DEBOUNCE_CYCLES=4, that is the 6th edge sampling low.
- Entry capture, on the edge where press[0] is asserted:
  - If the buffer is empty, or is being consumed this edge (entry_valid & entry_ready): entry_data/entry_op <= synchronised sw_in[7:0]/[9:8] and entry_valid <= 1.
  - If entry_valid=1 and entry_ready=0: the press is dropped, entry_data/entry_op are unchanged, and overrun <= 1. overrun clears only on reset.
- Handshake:
  - entry_valid & entry_ready at an edge with no concurrent capture: entry_valid <= 0; data retained but meaningless.
  - entry_ready while entry_valid=0 has no effect.
  - entry_data/entry_op are stable while entry_valid=1 until accepted.
- press[3:1] do not interact with the buffer; they are forwarded for core use (op keys). The board ties KEY[1] to reset at top level; the block still conditions it.
- Output registers: press and entry_valid are registers, with no combinational path from key_n or entry_ready to any output.

Test Plan:
- Reset, DEBOUNCE_CYCLES=4: hold resetb low 1 cycle, key_n=4'hF -> all outputs 0, key_level=4'hF, overrun=0.
- Clean enter press: sw_in=10'h0A9, key_n[0] low 10 cycles, entry_ready=0 -> one press[0] pulse 6 edges after first low sample; entry_valid=1, entry_data=8'hA9, entry_op=2'b00; no second pulse on release.
- Glitch rejection: key_n[0] low 3 cycles, high 1, low 3 -> no press, key_level[0] stays 1, entry_valid stays 0.
- Overrun: entry pending (8'hA9), sw_in=10'h355, second enter press with entry_ready=0 -> entry_data stays 8'hA9, overrun=1. Then entry_ready=1 one cycle -> entry_valid=0, overrun stays 1.
- Simultaneous consume and capture: entry_valid=1 and entry_ready=1 on the edge press[0] asserts with sw_in=10'h212 -> entry_valid stays 1, entry_data=8'h12, entry_op=2'b10, overrun unchanged.
- Reset mid-operation: key_n[2] low for 2 debounce cycles and entry pending, assert resetb -> entry_valid=0, cnt cleared. Key still held after reset -> press[2] only after a full 4-sample debounce.
